// File: rtl/eject_sink.sv
// Terminal ejection endpoint: consumes router staging flits, reassembles packets per VC,
// returns delayed credits and keeps packet/flit/latency statistics for the harness.
module eject_sink #(
  parameter int unsigned MY_ID        = 0,
  parameter int unsigned NUM_VC       = 4,
  parameter int unsigned CR_DELAY_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  op,
  input  logic [31:0] in_flit,
  input  logic [15:0] in_cycle,
  input  logic [3:0]  cr_delay,
  input  logic [15:0] expected_pkts,
  output logic [31:0] out_cr,
  output logic [15:0] pkt_count,
  output logic [15:0] flit_count,
  output logic [15:0] last_latency,
  output logic [15:0] max_latency,
  output logic [2:0]  err,
  output logic        done
);

  localparam logic [1:0] OpLoad = 2'd1;
  localparam logic [1:0] OpPh0  = 2'd2;
  localparam logic [1:0] OpPh1  = 2'd3;
  localparam logic [7:0] MyId   = 8'(MY_ID);
  localparam logic [4:0] CrMax  = 5'(CR_DELAY_MAX);

  typedef enum logic {StIdle, StOpen} vc_state_e;

  // Reserved flit bits carry nothing the sink needs.
  logic unused_rsvd;
  assign unused_rsvd = ^in_flit[2:0];

  logic [31:3] cap_q, cap_d;
  logic        ph0_done_q, ph0_done_d;
  logic        ph1_done_q, ph1_done_d;
  logic [2:0]  dly_q [CR_DELAY_MAX];
  logic [2:0]  dly_d [CR_DELAY_MAX];
  logic [2:0]  cr_q, cr_d;
  logic [15:0] pkt_q, pkt_d;
  logic [15:0] flit_q, flit_d;
  logic [15:0] last_q, last_d;
  logic [15:0] max_q, max_d;
  logic [2:0]  err_q, err_d;
  vc_state_e   vc_q [NUM_VC];
  vc_state_e   vc_d [NUM_VC];

  logic        head, tail, complete, all_idle;
  logic [1:0]  vc;
  logic [4:0]  eff;
  logic [15:0] lat;

  assign head = cap_q[30];
  assign tail = cap_q[29];
  assign vc   = cap_q[28:27];
  assign lat  = in_cycle - cap_q[18:3];

  always_comb begin
    if (cr_delay == 4'd0) begin
      eff = 5'd1;
    end else if ({1'b0, cr_delay} > CrMax) begin
      eff = CrMax;
    end else begin
      eff = {1'b0, cr_delay};
    end
  end

  always_comb begin
    cap_d      = cap_q;
    ph0_done_d = ph0_done_q;
    ph1_done_d = ph1_done_q;
    dly_d      = dly_q;
    cr_d       = cr_q;
    pkt_d      = pkt_q;
    flit_d     = flit_q;
    last_d     = last_q;
    max_d      = max_q;
    err_d      = err_q;
    vc_d       = vc_q;
    complete   = 1'b0;

    unique case (op)
      OpLoad: begin
        cap_d      = in_flit[31:3];
        cr_d       = dly_q[0];
        ph0_done_d = 1'b0;
        ph1_done_d = 1'b0;
      end
      OpPh0: begin
        // Only the first Phase0 after a LoadStaging acts on the captured flit.
        if (!ph0_done_q) begin
          ph0_done_d = 1'b1;
          if (cap_q[31]) begin
            if (flit_q != 16'hFFFF) flit_d = flit_q + 16'd1;
            if (cap_q[26:19] != MyId) err_d[0] = 1'b1;
            for (int unsigned v = 0; v < NUM_VC; v++) begin
              if (2'(v) == vc) begin
                unique case (vc_q[v])
                  StIdle: begin
                    if (!head) begin
                      err_d[1] = 1'b1;
                    end else if (tail) begin
                      complete = 1'b1;
                    end else begin
                      vc_d[v] = StOpen;
                    end
                  end
                  StOpen: begin
                    if (head) begin
                      // Abandon the open packet; the new head restarts it.
                      err_d[2] = 1'b1;
                      complete = tail;
                      vc_d[v]  = tail ? StIdle : StOpen;
                    end else if (tail) begin
                      complete = 1'b1;
                      vc_d[v]  = StIdle;
                    end
                  end
                  default: ;
                endcase
              end
            end
            if (complete) begin
              if (pkt_q != 16'hFFFF) pkt_d = pkt_q + 16'd1;
              last_d = lat;
              if (lat > max_q) max_d = lat;
            end
          end
        end
      end
      OpPh1: begin
        if (!ph1_done_q) begin
          ph1_done_d = 1'b1;
          for (int unsigned i = 0; i + 1 < CR_DELAY_MAX; i++) begin
            dly_d[i] = dly_q[i+1];
          end
          dly_d[CR_DELAY_MAX-1] = 3'b000;
          // A new credit overwrites whatever shifted into its slot.
          if (cap_q[31]) begin
            for (int unsigned i = 0; i < CR_DELAY_MAX; i++) begin
              if (5'(i) + 5'd1 == eff) dly_d[i] = {1'b1, vc};
            end
          end
          cap_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_q      <= '0;
      ph0_done_q <= 1'b0;
      ph1_done_q <= 1'b0;
      cr_q       <= '0;
      pkt_q      <= '0;
      flit_q     <= '0;
      last_q     <= '0;
      max_q      <= '0;
      err_q      <= '0;
      for (int unsigned i = 0; i < CR_DELAY_MAX; i++) dly_q[i] <= '0;
      for (int unsigned v = 0; v < NUM_VC; v++) vc_q[v] <= StIdle;
    end else begin
      cap_q      <= cap_d;
      ph0_done_q <= ph0_done_d;
      ph1_done_q <= ph1_done_d;
      cr_q       <= cr_d;
      pkt_q      <= pkt_d;
      flit_q     <= flit_d;
      last_q     <= last_d;
      max_q      <= max_d;
      err_q      <= err_d;
      dly_q      <= dly_d;
      vc_q       <= vc_d;
    end
  end

  always_comb begin
    all_idle = 1'b1;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (vc_q[v] != StIdle) all_idle = 1'b0;
    end
  end

  assign out_cr       = {cr_q[2], 2'b00, cr_q[1:0], 27'd0};
  assign pkt_count    = pkt_q;
  assign flit_count   = flit_q;
  assign last_latency = last_q;
  assign max_latency  = max_q;
  assign err          = err_q;
  assign done         = rst_n && (pkt_q >= expected_pkts) && all_idle;

endmodule

// File: tb/tb_eject_sink.sv
// Bench for eject_sink: credit scoreboard keyed by due network cycle, a vector table for
// interleaved reassembly, and short sequences for error, delay-clamp and reset corners.
module tb_eject_sink;

  localparam int CrMax = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  op;
  logic [31:0] in_flit;
  logic [15:0] in_cycle;
  logic [3:0]  cr_delay;
  logic [15:0] expected_pkts;
  logic [31:0] out_cr;
  logic [15:0] pkt_count, flit_count, last_latency, max_latency;
  logic [2:0]  err;
  logic        done;

  always #5 clk = ~clk;

  eject_sink #(.MY_ID(0), .NUM_VC(4), .CR_DELAY_MAX(CrMax)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op           (op),
    .in_flit      (in_flit),
    .in_cycle     (in_cycle),
    .cr_delay     (cr_delay),
    .expected_pkts(expected_pkts),
    .out_cr       (out_cr),
    .pkt_count    (pkt_count),
    .flit_count   (flit_count),
    .last_latency (last_latency),
    .max_latency  (max_latency),
    .err          (err),
    .done         (done)
  );

  typedef struct {
    int         due;
    logic [1:0] vc;
  } cred_t;

  typedef struct {
    logic        h;
    logic        t;
    logic [1:0]  vc;
    logic [15:0] inj;
    logic [15:0] pc;
    logic [15:0] fc;
    logic [15:0] lat;
    logic        dn;
  } vec_t;

  cred_t sb[$];
  vec_t  vt[5];
  int    n_cmp = 0;
  int    n_err = 0;
  int    ncyc = 0;
  int    credits_seen = 0;

  function automatic logic [31:0] mkflit(input logic h, input logic t, input logic [1:0] v,
                                         input logic [7:0] dest, input logic [15:0] inj);
    return {1'b1, h, t, v, dest, inj, 3'b000};
  endfunction

  function automatic vec_t mkv(input logic h, input logic t, input logic [1:0] v,
                               input int inj, input int pc, input int fc, input int lat,
                               input logic dn);
    vec_t r;
    r.h = h; r.t = t; r.vc = v; r.inj = 16'(inj);
    r.pc = 16'(pc); r.fc = 16'(fc); r.lat = 16'(lat); r.dn = dn;
    return r;
  endfunction

  function automatic int eff_of(input logic [3:0] d);
    if (d == 4'd0) return 1;
    if (int'(d) > CrMax) return CrMax;
    return int'(d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic op_step(input logic [1:0] o);
    op = o;
    @(posedge clk);
    #1;
    op = 2'd0;
  endtask

  // One network cycle; dup issues Phase0 twice to exercise the repeat guard.
  task automatic net_cycle(input logic [31:0] flit, input bit dup);
    logic [31:0] exp_cr;
    exp_cr   = '0;
    in_flit  = flit;
    in_cycle = 16'(ncyc);
    op_step(2'd1);
    if (sb.size() > 0 && sb[0].due == ncyc) begin
      exp_cr = {1'b1, 2'b00, sb[0].vc, 27'd0};
      void'(sb.pop_front());
    end
    if (out_cr[31]) credits_seen++;
    check($sformatf("out_cr@%0d", ncyc), out_cr, exp_cr);
    op_step(2'd2);
    if (dup) op_step(2'd2);
    op_step(2'd3);
    if (flit[31]) sb.push_back('{due: ncyc + eff_of(cr_delay), vc: flit[28:27]});
    in_flit = '0;
    ncyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) net_cycle(32'd0, 1'b0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    op    = 2'd0;
    in_flit = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
  endtask

  initial begin
    rst_n = 1'b0; op = 2'd0; in_flit = '0; in_cycle = '0;
    cr_delay = 4'd3; expected_pkts = 16'd1;

    // Reset state and single-flit packet latency/credit timing
    reset_dut();
    check("rst_out_cr", out_cr, 32'd0);
    check("rst_pkt", {16'd0, pkt_count}, 32'd0);
    check("rst_flit", {16'd0, flit_count}, 32'd0);
    check("rst_err", {29'd0, err}, 32'd0);
    check("rst_max", {16'd0, max_latency}, 32'd0);
    ncyc = 9;
    net_cycle(mkflit(1'b1, 1'b1, 2'd1, 8'd0, 16'd5), 1'b0);
    check("t1_pkt", {16'd0, pkt_count}, 32'd1);
    check("t1_lat", {16'd0, last_latency}, 32'd4);
    idle(4);
    check("t1_cr_8800", {31'd0, credits_seen == 1}, 32'd1);
    check("t1_drained", sb.size(), 32'd0);

    // Interleaved packets on vc2 (3 flits) and vc0 (2 flits)
    vt[0] = mkv(1'b1, 1'b0, 2'd2, 100, 0, 1, 0, 1'b0);
    vt[1] = mkv(1'b1, 1'b0, 2'd0, 101, 0, 2, 0, 1'b0);
    vt[2] = mkv(1'b0, 1'b0, 2'd2, 100, 0, 3, 0, 1'b0);
    vt[3] = mkv(1'b0, 1'b1, 2'd0, 101, 1, 4, 2, 1'b0);
    vt[4] = mkv(1'b0, 1'b1, 2'd2, 100, 2, 5, 4, 1'b1);
    reset_dut();
    cr_delay = 4'd1; expected_pkts = 16'd2; ncyc = 100;
    for (int i = 0; i < 5; i++) begin
      net_cycle(mkflit(vt[i].h, vt[i].t, vt[i].vc, 8'd0, vt[i].inj), 1'b0);
      check($sformatf("v%0d_pkt", i), {16'd0, pkt_count}, {16'd0, vt[i].pc});
      check($sformatf("v%0d_flit", i), {16'd0, flit_count}, {16'd0, vt[i].fc});
      check($sformatf("v%0d_lat", i), {16'd0, last_latency}, {16'd0, vt[i].lat});
      check($sformatf("v%0d_err", i), {29'd0, err}, 32'd0);
      check($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, vt[i].dn});
    end
    check("t2_max", {16'd0, max_latency}, 32'd4);
    idle(2);

    // Body on idle VC, then a head while the VC is open; repeated Phase0 counts once
    reset_dut();
    cr_delay = 4'd2; expected_pkts = 16'd1; ncyc = 200; credits_seen = 0;
    net_cycle(mkflit(1'b0, 1'b0, 2'd3, 8'd0, 16'd0), 1'b0);
    check("t3_err_body", {29'd0, err}, 32'b010);
    check("t3_flit1", {16'd0, flit_count}, 32'd1);
    check("t3_pkt0", {16'd0, pkt_count}, 32'd0);
    idle(2);
    check("t3_body_credit", credits_seen, 32'd1);
    net_cycle(mkflit(1'b1, 1'b0, 2'd3, 8'd0, 16'd200), 1'b1);
    check("t3_dup_ph0", {16'd0, flit_count}, 32'd2);
    check("t3_open_notdone", {31'd0, done}, 32'd0);
    net_cycle(mkflit(1'b1, 1'b0, 2'd3, 8'd0, 16'd203), 1'b0);
    check("t3_err_head", {29'd0, err}, 32'b110);
    net_cycle(mkflit(1'b0, 1'b1, 2'd3, 8'd0, 16'd203), 1'b0);
    check("t3_pkt1", {16'd0, pkt_count}, 32'd1);
    check("t3_lat", {16'd0, last_latency}, 32'd2);
    idle(3);

    // Misrouted packet still counts
    reset_dut();
    cr_delay = 4'd1; ncyc = 300;
    net_cycle(mkflit(1'b1, 1'b1, 2'd0, 8'd5, 16'd298), 1'b0);
    check("t4_err", {29'd0, err}, 32'b001);
    check("t4_pkt", {16'd0, pkt_count}, 32'd1);
    check("t4_lat", {16'd0, last_latency}, 32'd2);
    idle(1);

    // Delay clamps and a flit every cycle
    reset_dut();
    cr_delay = 4'd0; ncyc = 400;
    net_cycle(mkflit(1'b1, 1'b1, 2'd1, 8'd0, 16'd400), 1'b0);
    idle(2);
    check("t5_d0_drained", sb.size(), 32'd0);
    cr_delay = 4'd15;
    net_cycle(mkflit(1'b1, 1'b1, 2'd2, 8'd0, 16'd403), 1'b0);
    idle(9);
    check("t5_d15_drained", sb.size(), 32'd0);
    cr_delay = 4'd4; credits_seen = 0;
    for (int i = 0; i < 20; i++) begin
      net_cycle(mkflit(1'b1, 1'b1, 2'(i % 4), 8'd0, 16'(ncyc)), 1'b0);
    end
    idle(5);
    check("t5_credits20", credits_seen, 32'd20);
    check("t5_drained", sb.size(), 32'd0);
    check("t5_pkt", {16'd0, pkt_count}, 32'd22);

    // Reset with credits pending
    reset_dut();
    cr_delay = 4'd5; ncyc = 500;
    for (int i = 0; i < 3; i++) net_cycle(mkflit(1'b1, 1'b1, 2'd3, 8'd0, 16'(ncyc)), 1'b0);
    expected_pkts = 16'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_done_in_rst", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    sb.delete();
    #1;
    check("t6_done_after", {31'd0, done}, 32'd1);
    credits_seen = 0;
    idle(8);
    check("t6_no_credit", credits_seen, 32'd0);
    check("t6_pkt", {16'd0, pkt_count}, 32'd0);
    check("t6_flit", {16'd0, flit_count}, 32'd0);
    check("t6_err", {29'd0, err}, 32'd0);
    check("t6_lat", {16'd0, last_latency}, 32'd0);
    check("t6_max", {16'd0, max_latency}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eject_sink.md
Name: eject_sink

Overview:
- Terminal ejection endpoint attached to one router output port in the NoC simulation fabric.
- Receiver side of the staging/credit link: it consumes flits the router drives on its staging output and returns one credit per consumed flit on the credit staging path after a configurable delay.
- Reassembles packets per VC, checks framing and destination, and reports packet, flit and latency statistics to the top-level harness.
- Advances only on the harness op sequence LoadStaging -> Phase0 -> Phase1, one network cycle per pass.

Parameters:
- MY_ID, 0, router index this sink is attached to; compared against the flit destination field.
- NUM_VC, 4, number of virtual channels; VC field width is fixed at 2 bits.
- CR_DELAY_MAX, 8, depth of the credit delay line; the legal cr_delay range is 1..CR_DELAY_MAX.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- op  in  2  0=NOP, 1=LoadStaging, 2=Phase0, 3=Phase1.
- in_flit  in  32  flit from the router staging output. Fields: [31] valid, [30] head, [29] tail, [28:27] vc, [26:19] dest, [18:3] injection cycle, [2:0] reserved.
- in_cycle  in  16  current network cycle from the harness.
- cr_delay  in  4  credit return delay, in network cycles.
- expected_pkts  in  16  number of packets after which the sink reports done.
- out_cr  out  32  credit staging word. [31] valid, [28:27] vc, all other bits 0.
- pkt_count  out  16  completed packets; saturates at 16'hFFFF.
- flit_count  out  16  consumed flits; saturates at 16'hFFFF.
- last_latency  out  16  in_cycle minus injection cycle of the most recent tail flit, mod 2^16.
- max_latency  out  16  largest last_latency recorded.
- err  out  3  sticky error flags. [0] misroute, [1] body or tail flit with no open packet, [2] head flit while a packet is already open.
- done  out  1  pkt_count >= expected_pkts and all VCs idle.

Behaviour:
- Reset: on a clk edge with rst_n=0, every output, the capture register, the per-VC state, the delay line and the statistics clear to 0.
  - Reset mid-sequence discards pending credits and any open packets.
  - done reads 0 while held in reset, even when expected_pkts=0.
- NOP: no state change.
- LoadStaging (network cycle n):
  - Capture in_flit into the capture register.
  - Drive out_cr from delay-line slot 0; out_cr holds that value until the next LoadStaging.
- Phase0: process the captured flit only if its valid bit is 1.
  - flit_count += 1.
  - dest != MY_ID sets err[0]. Packet reassembly still proceeds.
  - Per-VC FSM, states IDLE and OPEN:
    - IDLE + head&tail: packet completes; state stays IDLE.
    - IDLE + head&!tail: go to OPEN.
    - IDLE + !head: set err[1]; flit is dropped from reassembly but still credited.
    - OPEN + head: set err[2]; the open packet is abandoned and the new head restarts it (OPEN, or IDLE if the head also has tail set).
    - OPEN + tail: packet completes; go to IDLE.
    - OPEN + body: stay OPEN.
  - On packet completion: pkt_count += 1; last_latency = in_cycle - flit[18:3]; max_latency = max(max_latency, new latency).
- Phase1:
  - Shift the delay line toward slot 0; slot CR_DELAY_MAX-1 refills with 0.
  - If the captured flit was valid, write {valid=1, vc} into slot eff-1, where eff = cr_delay, except cr_delay=0 uses eff=1 and cr_delay>CR_DELAY_MAX uses eff=CR_DELAY_MAX.
  - Then clear the capture register.
  - Net timing: a flit captured at LoadStaging of cycle n has its credit on out_cr from LoadStaging of cycle n+eff.
  - A slot write collides only with the shifted value when cr_delay decreases mid-run. In that case the new credit wins and the displaced credit is lost; this is documented, and the harness holds cr_delay constant.
- Repeated ops, e.g. Phase0 twice in a row: only the first Phase0 after a LoadStaging processes the flit; later ones are no-ops.
- Saturating counters stop at 16'hFFFF; latency arithmetic wraps mod 2^16.
- done updates combinationally from the registered counters and VC states.

Test Plan:
- Reset, then a single-flit packet (head+tail, vc=1, dest=MY_ID, inj=5) at in_cycle=9 with cr_delay=3 -> pkt_count=1, last_latency=4, out_cr=32'h8800_0000 at LoadStaging of cycle 12 and 0 at cycles 10, 11 and 13.
- 3-flit packet on vc=2 interleaved with a 2-flit packet on vc=0 over consecutive cycles -> pkt_count=2, flit_count=5, err=0, done=1 with expected_pkts=2.
- Body flit on idle vc=3 -> err[1]=1, flit_count=1, credit still returned; a subsequent head on vc=3 while it is OPEN -> err[2]=1.
- Flit with dest != MY_ID -> err[0]=1; the packet still counts.
- cr_delay=0 -> credit appears 1 cycle after capture. cr_delay=15 with CR_DELAY_MAX=8 -> credit appears 8 cycles after capture. A flit every cycle for 20 cycles -> exactly 20 credits, in order.
- Assert rst_n=0 while 3 credits are pending -> out_cr stays 0 afterwards and all counters and err read 0.
